// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared execute-stage constants: shift modes and shift unit state encoding
package cpu_pkg;

  // Shift/rotate operation select
  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_ROTR = 2'b11;

  // Shift unit controller states
  typedef enum logic [1:0] {
    SHU_IDLE  = 2'd0,
    SHU_SHIFT = 2'd1,
    SHU_DONE  = 2'd2
  } shu_state_e;

endpackage

// File: rtl/shift_unit_if.sv
// rtl/shift_unit_if.sv - request/result bundle between issue logic and the shift unit
interface shift_unit_if #(
  parameter int WIDTH = 32,
  parameter int SA_W  = 5
);

  logic             start;
  logic [1:0]       mode;
  logic             sa_sel;
  logic [SA_W-1:0]  imm_sa;
  logic [WIDTH-1:0] reg_sa;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  // Issuing side: drives the request, observes status and result
  modport master (
    output start, mode, sa_sel, imm_sa, reg_sa, din,
    input  busy, done, dout
  );

  // Shift unit side
  modport slave (
    input  start, mode, sa_sel, imm_sa, reg_sa, din,
    output busy, done, dout
  );

endinterface

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one logarithmic barrel stage: shift/rotate by 2^k or pass through
module shift_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SA_W  = 5
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  input  logic [SA_W-1:0]  k_i,
  input  logic             en_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  // Stage distance is 2^k; never exceeds WIDTH/2 since k < SA_W
  logic [SA_W:0]    shamt;
  logic [WIDTH-1:0] srl_val;
  logic [WIDTH-1:0] fill_mask;

  assign shamt     = (SA_W + 1)'(1) << k_i;
  assign srl_val   = data_i >> shamt;
  assign fill_mask = ~({WIDTH{1'b1}} >> shamt);

  // Select the stage result for the captured mode, or pass through when this sa bit is clear
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (mode_i)
        SH_SLL:  data_o = data_i << shamt;
        SH_SRL:  data_o = srl_val;
        SH_SRA:  data_o = srl_val | (fill_i ? fill_mask : '0);
        default: data_o = srl_val | (data_i << (WIDTH - int'(shamt)));
      endcase
    end
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multi-cycle shift/rotate unit, one barrel stage resolved per clock
module shift_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SA_W  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_unit_if.slave bus
);

  shu_state_e       state_q, state_d;
  logic [SA_W-1:0]  k_q, k_d;
  logic [SA_W-1:0]  sa_q, sa_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic [SA_W-1:0]  sa_src;
  logic             stage_en;
  logic [WIDTH-1:0] stage_out;
  logic             capture;

  // Shift amount: instruction field or low bits of the register operand
  assign sa_src   = bus.sa_sel ? bus.reg_sa[SA_W-1:0] : bus.imm_sa;
  // Current stage is active only when the matching captured sa bit is set
  assign stage_en = |(sa_q & (SA_W'(1) << k_q));

  shift_stage #(
    .WIDTH (WIDTH),
    .SA_W  (SA_W)
  ) u_stage (
    .data_i (data_q),
    .mode_i (mode_q),
    .k_i    (k_q),
    .en_i   (stage_en),
    .fill_i (fill_q),
    .data_o (stage_out)
  );

  // Next-state logic: capture from IDLE or DONE, walk stages in SHIFT, publish result on entry to DONE
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sa_d    = sa_q;
    mode_d  = mode_q;
    data_d  = data_q;
    fill_d  = fill_q;
    dout_d  = dout_q;
    capture = 1'b0;

    case (state_q)
      SHU_IDLE: begin
        capture = bus.start;
      end
      SHU_SHIFT: begin
        data_d = stage_out;
        k_d    = k_q + SA_W'(1);
        if (k_q == SA_W'(SA_W - 1)) begin
          state_d = SHU_DONE;
          dout_d  = stage_out;
          k_d     = '0;
        end
      end
      SHU_DONE: begin
        capture = bus.start;
        if (!bus.start) begin
          state_d = SHU_IDLE;
        end
      end
      default: begin
        state_d = SHU_IDLE;
      end
    endcase

    // Operands are sampled only here; later input changes are ignored
    if (capture) begin
      state_d = SHU_SHIFT;
      k_d     = '0;
      sa_d    = sa_src;
      mode_d  = bus.mode;
      data_d  = bus.din;
      fill_d  = bus.din[WIDTH-1];
    end
  end

  // State and datapath registers; reset aborts any request in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHU_IDLE;
      k_q     <= '0;
      sa_q    <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sa_q    <= sa_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.busy = (state_q == SHU_SHIFT);
  assign bus.done = (state_q == SHU_DONE);
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - self-checking bench for shift_unit at 32 and 16 bit widths
module tb_shift_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_unit_if #(.WIDTH(32), .SA_W(5)) bus32 ();
  shift_unit_if #(.WIDTH(16), .SA_W(4)) bus16 ();

  shift_unit #(.WIDTH(32), .SA_W(5)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  shift_unit #(.WIDTH(16), .SA_W(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  // Reference: whole-amount shift/rotate on a w-bit value using plain arithmetic
  function automatic logic [31:0] ref_op(int w, logic [1:0] mode, logic [31:0] d, int sa);
    logic [63:0] mask, x, r;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    sa   = sa % w;
    case (mode)
      SH_SLL:  r = (x << sa) & mask;
      SH_SRL:  r = x >> sa;
      SH_SRA:  begin
        r = x >> sa;
        if (x[w-1]) r = r | (mask & ~(mask >> sa));
      end
      default: r = (sa == 0) ? x : (((x >> sa) | (x << (w - sa))) & mask);
    endcase
    return r[31:0];
  endfunction

  // Issue one 32-bit request, scramble inputs after capture, wait for done
  task automatic run32(input logic [1:0] mode, input logic sa_sel, input logic [4:0] imm,
                       input logic [31:0] rsa, input logic [31:0] din,
                       output logic [31:0] res, output int lat, output int busy_cyc);
    @(negedge clk);
    bus32.start = 1'b1; bus32.mode = mode; bus32.sa_sel = sa_sel;
    bus32.imm_sa = imm; bus32.reg_sa = rsa; bus32.din = din;
    @(posedge clk); #1;
    bus32.start = 1'b0; bus32.din = $urandom; bus32.reg_sa = $urandom;
    bus32.imm_sa = 5'($urandom); bus32.mode = 2'($urandom); bus32.sa_sel = 1'($urandom);
    lat = 0; res = 'x;
    busy_cyc = bus32.busy ? 1 : 0;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (bus32.done) begin res = bus32.dout; break; end
      if (bus32.busy) busy_cyc++;
    end
  endtask

  task automatic run16(input logic [1:0] mode, input logic sa_sel, input logic [3:0] imm,
                       input logic [15:0] rsa, input logic [15:0] din,
                       output logic [15:0] res, output int lat, output int busy_cyc);
    @(negedge clk);
    bus16.start = 1'b1; bus16.mode = mode; bus16.sa_sel = sa_sel;
    bus16.imm_sa = imm; bus16.reg_sa = rsa; bus16.din = din;
    @(posedge clk); #1;
    bus16.start = 1'b0; bus16.din = 16'($urandom); bus16.reg_sa = 16'($urandom);
    bus16.imm_sa = 4'($urandom); bus16.mode = 2'($urandom);
    lat = 0; res = 'x;
    busy_cyc = bus16.busy ? 1 : 0;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (bus16.done) begin res = bus16.dout; break; end
      if (bus16.busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    bus32.start = 0; bus32.mode = 0; bus32.sa_sel = 0; bus32.imm_sa = 0; bus32.reg_sa = 0; bus32.din = 0;
    bus16.start = 0; bus16.mode = 0; bus16.sa_sel = 0; bus16.imm_sa = 0; bus16.reg_sa = 0; bus16.din = 0;
    rst_n = 1'b0;
    #12;
    checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus32.busy); end
    checks++; if (bus32.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus32.done); end
    checks++; if (bus32.dout !== 32'd0) begin errors++; $display("FAIL reset_dout got=%h exp=0", bus32.dout); end
    checks++; if (bus16.dout !== 16'd0 || bus16.busy !== 1'b0) begin errors++; $display("FAIL reset_dut16 dout=%h busy=%b exp=0", bus16.dout, bus16.busy); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sll();
    logic [31:0] res; int lat, bc;
    run32(SH_SLL, 1'b0, 5'd31, 32'h0, 32'h0000_0001, res, lat, bc);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL sll31_result got=%h exp=80000000", res); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL sll31_latency got=%0d exp=5", lat); end
    checks++; if (bc !== 5) begin errors++; $display("FAIL sll31_busy_cycles got=%0d exp=5", bc); end
  endtask

  task automatic test_reg_sa();
    logic [31:0] res; int lat, bc;
    run32(SH_SRA, 1'b1, 5'd9, 32'hFFFF_FFE4, 32'h8000_0000, res, lat, bc);
    checks++; if (res !== 32'hF800_0000) begin errors++; $display("FAIL sra_reg_result got=%h exp=f8000000", res); end
    run32(SH_SRL, 1'b1, 5'd9, 32'hFFFF_FFE4, 32'h8000_0000, res, lat, bc);
    checks++; if (res !== 32'h0800_0000) begin errors++; $display("FAIL srl_reg_result got=%h exp=08000000", res); end
  endtask

  task automatic test_rotr();
    logic [31:0] res; int lat, bc;
    run32(SH_ROTR, 1'b0, 5'd8, 32'h0, 32'h1234_5678, res, lat, bc);
    checks++; if (res !== 32'h7812_3456) begin errors++; $display("FAIL rotr8_result got=%h exp=78123456", res); end
    run32(SH_ROTR, 1'b0, 5'd0, 32'h0, 32'h1234_5678, res, lat, bc);
    checks++; if (res !== 32'h1234_5678) begin errors++; $display("FAIL rotr0_result got=%h exp=12345678", res); end
    checks++; if (lat !== 5 || bc !== 5) begin errors++; $display("FAIL rotr0_latency got=%0d/%0d exp=5/5", lat, bc); end
  endtask

  task automatic test_random();
    logic [31:0] res, din, rsa, exp; logic [4:0] imm; logic [1:0] mode; logic sel; int lat, bc, sa;
    for (int i = 0; i < 40; i++) begin
      din = $urandom; rsa = $urandom; imm = 5'($urandom); mode = 2'($urandom); sel = 1'($urandom);
      sa  = sel ? int'(rsa % 32) : int'(imm);
      exp = ref_op(32, mode, din, sa);
      run32(mode, sel, imm, rsa, din, res, lat, bc);
      checks++; if (res !== exp || lat !== 5) begin errors++; $display("FAIL random32_%0d mode=%0d sa=%0d din=%h got=%h lat=%0d exp=%h lat=5", i, mode, sa, din, res, lat, exp); end
    end
  endtask

  task automatic test_ignore_busy();
    logic [31:0] res, exp; int lat, extra;
    exp = ref_op(32, SH_SLL, 32'h0000_00F0, 4);
    @(negedge clk);
    bus32.start = 1; bus32.mode = SH_SLL; bus32.sa_sel = 0; bus32.imm_sa = 5'd4; bus32.din = 32'h0000_00F0;
    @(posedge clk); #1; bus32.start = 0;
    lat = 0; res = 'x;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (bus32.done) begin res = bus32.dout; break; end
      if (lat == 1) begin
        bus32.start = 1; bus32.mode = SH_SRL; bus32.imm_sa = 5'd1; bus32.din = 32'hFFFF_FFFF;
      end
      if (lat == 2) bus32.start = 0;
    end
    checks++; if (res !== exp || res !== 32'h0000_0F00) begin errors++; $display("FAIL busy_start_result got=%h exp=00000f00", res); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL busy_start_latency got=%0d exp=5", lat); end
    extra = 0;
    repeat (10) begin @(posedge clk); #1; if (bus32.done) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_queued got=%0d extra done exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res_a, res_b; int lat, gap;
    @(negedge clk);
    bus32.start = 1; bus32.mode = SH_SRA; bus32.sa_sel = 0; bus32.imm_sa = 5'd12; bus32.din = 32'h9ABC_DEF0;
    @(posedge clk); #1; bus32.start = 0;
    lat = 0; res_a = 'x;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (bus32.done) begin res_a = bus32.dout; break; end
    end
    bus32.start = 1; bus32.mode = SH_ROTR; bus32.sa_sel = 1; bus32.reg_sa = 32'h0000_0013; bus32.din = 32'hCAFE_0001;
    gap = 0; res_b = 'x;
    while (gap < 20) begin
      @(posedge clk); gap++; #1;
      if (gap == 1) bus32.start = 0;
      if (bus32.done) begin res_b = bus32.dout; break; end
    end
    checks++; if (res_a !== ref_op(32, SH_SRA, 32'h9ABC_DEF0, 12)) begin errors++; $display("FAIL b2b_first got=%h exp=%h", res_a, ref_op(32, SH_SRA, 32'h9ABC_DEF0, 12)); end
    checks++; if (res_b !== ref_op(32, SH_ROTR, 32'hCAFE_0001, 19)) begin errors++; $display("FAIL b2b_second got=%h exp=%h", res_b, ref_op(32, SH_ROTR, 32'hCAFE_0001, 19)); end
    checks++; if (gap !== 6) begin errors++; $display("FAIL b2b_gap got=%0d exp=6", gap); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int lat, bc, extra;
    run32(SH_SLL, 1'b0, 5'd0, 32'h0, 32'h1234_5678, res, lat, bc);
    checks++; if (res !== 32'h1234_5678) begin errors++; $display("FAIL pre_abort_dout got=%h exp=12345678", res); end
    @(negedge clk);
    bus32.start = 1; bus32.mode = SH_SRL; bus32.sa_sel = 0; bus32.imm_sa = 5'd3; bus32.din = 32'hFFFF_0000;
    @(posedge clk); #1; bus32.start = 0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus32.busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got=%b exp=1", bus32.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin errors++; $display("FAIL abort_async_ctrl busy=%b done=%b exp=0/0", bus32.busy, bus32.done); end
    checks++; if (bus32.dout !== 32'd0) begin errors++; $display("FAIL abort_async_dout got=%h exp=0", bus32.dout); end
    @(negedge clk); rst_n = 1'b1;
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (bus32.done) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_spurious_done got=%0d exp=0", extra); end
    run32(SH_SRL, 1'b0, 5'd3, 32'h0, 32'hFFFF_0000, res, lat, bc);
    checks++; if (res !== 32'h1FFF_E000 || lat !== 5) begin errors++; $display("FAIL post_abort_op got=%h lat=%0d exp=1fffe000 lat=5", res, lat); end
  endtask

  task automatic test_param16();
    logic [15:0] res, din, rsa, exp; logic [3:0] imm; logic [1:0] mode; logic sel; int lat, bc, sa;
    run16(SH_SRA, 1'b0, 4'd15, 16'h0, 16'h8001, res, lat, bc);
    checks++; if (res !== 16'hFFFF) begin errors++; $display("FAIL w16_sra15_result got=%h exp=ffff", res); end
    checks++; if (lat !== 4 || bc !== 4) begin errors++; $display("FAIL w16_latency got=%0d busy=%0d exp=4/4", lat, bc); end
    for (int i = 0; i < 20; i++) begin
      din = 16'($urandom); rsa = 16'($urandom); imm = 4'($urandom); mode = 2'($urandom); sel = 1'($urandom);
      sa  = sel ? int'(rsa % 16) : int'(imm);
      exp = 16'(ref_op(16, mode, {16'd0, din}, sa));
      run16(mode, sel, imm, rsa, din, res, lat, bc);
      checks++; if (res !== exp || lat !== 4) begin errors++; $display("FAIL random16_%0d mode=%0d sa=%0d din=%h got=%h lat=%0d exp=%h lat=4", i, mode, sa, din, res, lat, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_reg_sa();
    test_rotr();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_param16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
